// File: rtl/dfa_flow_sequencer.sv
// Per-flow DFA context sequencer: restores matcher state per flow, streams bytes, saves state and reports.
// Optional macro DPI_MATCH_CNT_EN enables the saturating per-packet accept count on res_cnt.
module dfa_flow_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pkt_data,
  input  logic        pkt_vld,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  input  logic [3:0]  pkt_flow,
  output logic        pkt_rdy,
  output logic [7:0]  dfa_char,
  output logic        dfa_char_vld,
  output logic [10:0] dfa_state_in,
  output logic        dfa_state_vld,
  input  logic [10:0] dfa_state_out,
  input  logic        dfa_accept,
  input  logic        flow_clr,
  input  logic [3:0]  flow_clr_id,
  output logic        res_vld,
  output logic        res_match,
  output logic        res_err,
  output logic [3:0]  res_flow,
  output logic [7:0]  res_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, SAVE, REPORT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  flow_q, flow_d;
  logic        first_q, first_d;
  logic        match_q, match_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] ld_state_q, ld_state_d;
  logic        ld_vld_q, ld_vld_d;
  logic        res_vld_q, res_vld_d;
  logic        res_match_q, res_match_d;
  logic        res_err_q, res_err_d;
  logic [3:0]  res_flow_q, res_flow_d;
  logic [7:0]  res_cnt_q, res_cnt_d;

  logic [10:0] flow_tbl [16];

  logic in_stream;
  logic sop_err;
  logic accept_byte;

  // The sop byte that opened the packet is still presented in the first STREAM cycle.
  assign in_stream   = (state_q == STREAM);
  assign sop_err     = in_stream & pkt_vld & pkt_sop & ~first_q;
  assign accept_byte = in_stream & pkt_vld & ~sop_err;

  always_comb begin
    state_d     = state_q;
    flow_d      = flow_q;
    first_d     = first_q;
    match_d     = match_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ld_state_d  = ld_state_q;
    ld_vld_d    = 1'b0;
    res_vld_d   = 1'b0;
    res_match_d = 1'b0;
    res_err_d   = 1'b0;
    res_flow_d  = '0;
    res_cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (pkt_vld && pkt_sop) begin
          flow_d     = pkt_flow;
          // A clear landing on the entry being read this cycle must be seen by the load.
          ld_state_d = (flow_clr && (flow_clr_id == pkt_flow)) ? '0 : flow_tbl[pkt_flow];
          ld_vld_d   = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        first_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (sop_err) begin
          err_d   = 1'b1;
          state_d = SAVE;
        end else if (accept_byte) begin
          first_d = 1'b0;
          if (dfa_accept) begin
            match_d = 1'b1;
`ifdef DPI_MATCH_CNT_EN
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
          end
          if (pkt_eop) state_d = SAVE;
        end
      end
      SAVE: begin
        res_vld_d   = 1'b1;
        res_match_d = match_q;
        res_err_d   = err_q;
        res_flow_d  = flow_q;
        res_cnt_d   = cnt_q;
        state_d     = REPORT;
      end
      REPORT: begin
        match_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flow_q      <= '0;
      first_q     <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ld_state_q  <= '0;
      ld_vld_q    <= 1'b0;
      res_vld_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_flow_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      flow_q      <= flow_d;
      first_q     <= first_d;
      match_q     <= match_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ld_state_q  <= ld_state_d;
      ld_vld_q    <= ld_vld_d;
      res_vld_q   <= res_vld_d;
      res_match_q <= res_match_d;
      res_err_q   <= res_err_d;
      res_flow_q  <= res_flow_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Save is issued after the clear so it takes priority on a shared entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) flow_tbl[i] <= '0;
    end else begin
      if (flow_clr) flow_tbl[flow_clr_id] <= '0;
      if (state_q == SAVE) flow_tbl[flow_q] <= dfa_state_out;
    end
  end

  assign pkt_rdy       = rst_n & in_stream & ~(pkt_vld & pkt_sop & ~first_q);
  assign dfa_char      = pkt_data;
  assign dfa_char_vld  = rst_n & accept_byte;
  assign dfa_state_in  = ld_state_q;
  assign dfa_state_vld = rst_n & ld_vld_q;
  assign res_vld       = rst_n & res_vld_q;
  assign res_match     = res_vld & res_match_q;
  assign res_err       = res_vld & res_err_q;
  assign res_flow      = res_vld ? res_flow_q : 4'd0;
  assign res_cnt       = res_vld ? res_cnt_q : 8'd0;

endmodule

// File: tb/tb_dfa_flow_sequencer.sv
// Bench for dfa_flow_sequencer: "CC" matcher model, per-packet result scoreboard and load-value queue.
module tb_dfa_flow_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pkt_data = '0;
  logic        pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic [3:0]  pkt_flow = '0;
  logic        pkt_rdy;
  logic [7:0]  dfa_char;
  logic        dfa_char_vld;
  logic [10:0] dfa_state_in;
  logic        dfa_state_vld;
  logic [10:0] dfa_state_out;
  logic        dfa_accept;
  logic        flow_clr = 1'b0;
  logic [3:0]  flow_clr_id = '0;
  logic        res_vld, res_match, res_err;
  logic [3:0]  res_flow;
  logic [7:0]  res_cnt;

  dfa_flow_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_flow(pkt_flow), .pkt_rdy(pkt_rdy),
    .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
    .dfa_state_in(dfa_state_in), .dfa_state_vld(dfa_state_vld),
    .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept),
    .flow_clr(flow_clr), .flow_clr_id(flow_clr_id),
    .res_vld(res_vld), .res_match(res_match), .res_err(res_err),
    .res_flow(res_flow), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Matcher for "CC": state 1 means the previous character was 'C'.
  logic [10:0] m_state = '0;
  assign dfa_state_out = m_state;
  assign dfa_accept    = dfa_char_vld && (m_state == 11'd1) && (dfa_char == 8'h43);
  always @(posedge clk) begin
    if (dfa_state_vld)     m_state <= dfa_state_in;
    else if (dfa_char_vld) m_state <= (dfa_char == 8'h43) ? 11'd1 : 11'd0;
  end

  typedef struct {
    logic [3:0] flow;
    logic       match;
    logic       err;
    logic [7:0] cnt;
    int         cyc;
  } res_t;

  res_t        res_q[$];
  logic [10:0] load_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] ecnt(input int n);
`ifdef DPI_MATCH_CNT_EN
    return (n > 255) ? 8'd255 : n[7:0];
`else
    return (n > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (dfa_state_vld) begin
      if (load_q.size() == 0) check("load_unexp", 1, 0);
      else begin
        logic [10:0] e;
        e = load_q.pop_front();
        check("load_state", dfa_state_in, e);
        $display("load flow=%0d state=%0d exp=%0d", dut.flow_q, dfa_state_in, e);
      end
    end
    if (res_vld) begin
      if (res_q.size() == 0) check("res_unexp", 1, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        check("res_flow", res_flow, r.flow);
        check("res_match", res_match, r.match);
        check("res_err", res_err, r.err);
        check("res_cnt", res_cnt, r.cnt);
        if (r.cyc >= 0) check("res_latency", cyc, r.cyc);
        $display("result flow=%0d match=%0d err=%0d cnt=%0d", res_flow, res_match, res_err, res_cnt);
      end
    end else begin
      check("res_idle_zero", {res_match, res_err, res_flow, res_cnt}, 0);
    end
  end

  task automatic push_res(input logic [3:0] f, input logic m, input logic e, input logic [7:0] c, input int cy);
    res_t r;
    r.flow = f; r.match = m; r.err = e; r.cnt = c; r.cyc = cy;
    res_q.push_back(r);
  endtask

  // Sends a packet; when eop_end is set the expected result is queued at eop acceptance.
  task automatic send_pkt(input logic [3:0] f, input string s, input bit eop_end, input bit clr_at_save,
                          input logic [10:0] exp_load, input logic exp_match, input logic [7:0] exp_cnt);
    int n;
    load_q.push_back(exp_load);
    for (int i = 0; i < s.len(); i++) begin
      pkt_vld  = 1'b1;
      pkt_sop  = (i == 0);
      pkt_eop  = eop_end && (i == s.len() - 1);
      pkt_data = s[i];
      pkt_flow = f;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!pkt_rdy && n < 50);
      if (!pkt_rdy) begin
        check("rdy_timeout", 0, 1);
        pkt_vld = 1'b0;
        return;
      end
      if (pkt_eop) push_res(f, exp_match, 1'b0, exp_cnt, cyc + 2);
      @(posedge clk);
      #1;
    end
    pkt_vld = 1'b0;
    pkt_sop = 1'b0;
    pkt_eop = 1'b0;
    if (clr_at_save) begin
      flow_clr    = 1'b1;
      flow_clr_id = f;
      @(posedge clk);
      #1;
      flow_clr = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    string long_s;
    long_s = "";
    for (int i = 0; i < 260; i++) long_s = {long_s, "C"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", pkt_rdy, 0);
    check("rst_char_vld", dfa_char_vld, 0);
    check("rst_state_vld", dfa_state_vld, 0);
    check("rst_res_vld", res_vld, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single packet containing the pattern
    send_pkt(4'd3, "xCCy", 1, 0, 11'd0, 1'b1, ecnt(1));
    idle(4);
    // State carried across packets of one flow
    send_pkt(4'd3, "xC", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd3, "Cy", 1, 0, 11'd1, 1'b1, ecnt(1));
    idle(4);
    // Interleaved flows keep separate contexts
    send_pkt(4'd3, "xC", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd5, "Cy", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd3, "C", 1, 0, 11'd1, 1'b1, ecnt(1));
    idle(4);
    // Clear while idle drops the saved context
    send_pkt(4'd3, "xC", 1, 0, 11'd1, 1'b0, ecnt(0));
    idle(4);
    flow_clr = 1'b1; flow_clr_id = 4'd3;
    idle(1);
    flow_clr = 1'b0;
    idle(2);
    send_pkt(4'd3, "Cy", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    // sop without eop: error result, then the new packet restores the saved context
    send_pkt(4'd2, "xC", 0, 0, 11'd0, 1'b0, ecnt(0));
    idle(2);
    push_res(4'd2, 1'b0, 1'b1, ecnt(0), -1);
    send_pkt(4'd2, "CC", 1, 0, 11'd1, 1'b1, ecnt(2));
    idle(4);
    // Counter saturation and a 1-byte packet
    send_pkt(4'd7, long_s, 1, 0, 11'd0, 1'b1, ecnt(259));
    idle(4);
    send_pkt(4'd7, "C", 1, 0, 11'd1, 1'b1, ecnt(1));
    idle(4);
    // Clear colliding with the save to the same entry: save wins
    send_pkt(4'd9, "C", 1, 1, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd9, "C", 1, 0, 11'd1, 1'b1, ecnt(1));
    idle(4);
    // Reset mid-packet discards it and zeroes the table
    send_pkt(4'd4, "xC", 0, 0, 11'd0, 1'b0, ecnt(0));
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdy", pkt_rdy, 0);
    check("midrst_res_vld", res_vld, 0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    send_pkt(4'd7, "x", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd2, "x", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(4);
    send_pkt(4'd9, "x", 1, 0, 11'd0, 1'b0, ecnt(0));
    idle(6);

    check("res_queue_empty", res_q.size(), 0);
    check("load_queue_empty", load_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
